countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per millisecond tick (100 MHz clk).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 maxtime  input  22  programmed duration in ms, unsigned, range 0..4,194,303.
REQ-005 load  input  1  one-cycle pulse; capture maxtime and start conversion.
REQ-006 start  input  1  one-cycle pulse; begin or resume countdown.
REQ-007 stop  input  1  one-cycle pulse; pause countdown.
REQ-008 clear  input  1  one-cycle pulse; abort to IDLE with zero time.
REQ-009 remaining_ms  output  22  ms left.
REQ-010 minutes  output  7  whole minutes of remaining_ms (0..69).
REQ-011 seconds  output  6  seconds field (0..59).
REQ-012 millis  output  10  ms field (0..999).
REQ-013 ready  output  1  high in ARMED; start is accepted.
REQ-014 running  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse on expiry.
REQ-016 alarm  output  1  level; high in DONE.

Function
REQ-017 FSM states SHALL be IDLE, CONVERT, ARMED, RUN, DONE; all outputs registered.
REQ-018 Command priority SHALL be clear > load > stop > start, evaluated in every state.
REQ-019 clear SHALL zero remaining_ms, minutes, seconds, millis and the prescaler, and go to IDLE.
REQ-020 load SHALL set remaining_ms and a work register to maxtime, zero minutes and seconds, clear the prescaler, and go to CONVERT; load during CONVERT restarts conversion.
REQ-021 In CONVERT, one step per cycle: if work>=60000, subtract 60000 and increment minutes; else if work>=1000, subtract 1000 and increment seconds; else set millis=work and exit.
REQ-022 CONVERT SHALL last exactly M+S+1 cycles (M minutes, S seconds), then go to ARMED if maxtime!=0, else IDLE.
REQ-023 start in ARMED SHALL enter RUN; start in any other state SHALL be ignored.
REQ-024 stop in RUN SHALL enter ARMED with the prescaler value held, so resume keeps the partial ms.
REQ-025 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and issue a tick on wrap.
REQ-026 On each tick, remaining_ms SHALL decrement by 1 and the fields SHALL decrement with borrow: millis 0->999 borrows a second; seconds 0->59 borrows a minute.
REQ-027 A tick with remaining_ms==1 SHALL enter DONE; in the cycle remaining_ms reads 0, done=1 and alarm=1.
REQ-028 remaining_ms SHALL never underflow: no decrement occurs outside RUN or at 0.
REQ-029 The invariant remaining_ms == 60000*minutes + 1000*seconds + millis SHALL hold in ARMED, RUN and DONE.
REQ-030 alarm SHALL stay high in DONE until load or clear; start and stop SHALL be ignored in DONE.
REQ-031 Simultaneous start and stop in RUN SHALL pause; in ARMED the FSM SHALL stay in ARMED.

Reset
REQ-032 While rst_n=0 at posedge clk, state SHALL be IDLE and all outputs, the prescaler and the work register SHALL be 0.
REQ-033 Reset SHALL override every command, including mid-CONVERT and mid-RUN.

Structure
REQ-034 Shared package timer_pkg SHALL hold the state encoding, MS_PER_MIN=60000, MS_PER_SEC=1000 and TIME_W=22; the programming block SHALL use the same constants.
REQ-035 The iterative converter SHALL be the sub-module ms_to_mmss, with a start/busy/valid handshake; prescaler and FSM stay in countdown_timer.

Verification (TICK_DIV=4)
REQ-036 load, maxtime=61500 -> 3 CONVERT cycles, then ARMED; minutes=1, seconds=1, millis=500, ready=1.
REQ-037 maxtime=2, load, start -> remaining_ms=1 after 4 cycles, 0 after 8; done pulses 1 cycle; alarm stays 1 until clear.
REQ-038 maxtime=1000 running, at 0 ms field -> next tick gives seconds=0, millis=999, remaining_ms=999.
REQ-039 stop 2 cycles after a tick, wait 10 cycles, start -> next tick 2 cycles after resume; no decrement while ARMED.
REQ-040 maxtime=4194303, load -> minutes=69, seconds=54, millis=303 after 124 cycles; maxtime=0, load -> IDLE, start ignored.
REQ-041 rst_n=0 mid-RUN, and clear+load in the same cycle -> IDLE with all outputs 0 (clear wins).

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: constants and state encoding shared by the countdown timer and
// its millisecond-to-mm:ss converter.
//   TIME_W      width of a millisecond count (0..4,194,303)
//   MIN_W/SEC_W/MS_W  widths of the minutes/seconds/millis fields
//   MS_PER_MIN, MS_PER_SEC  conversion constants
//   timer_state_e  FSM encoding of countdown_timer
package timer_pkg;

  localparam int TIME_W = 22;
  localparam int MIN_W  = 7;
  localparam int SEC_W  = 6;
  localparam int MS_W   = 10;

  localparam logic [TIME_W-1:0] MS_PER_MIN = 22'd60000;
  localparam logic [TIME_W-1:0] MS_PER_SEC = 22'd1000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_ARMED   = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } timer_state_e;

endpackage

// File: rtl/ms_to_mmss.sv
// ms_to_mmss: iterative converter from a millisecond count to
// minutes / seconds / millis, one subtraction step per clock.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             capture value and begin converting (restarts if busy)
//   abort             drop any conversion and zero the work state
//   value             millisecond count to convert
//   busy              conversion in progress
//   valid             results are final this cycle (combinational, only
//                     while busy); the converter goes idle at the next edge
//   minutes, seconds, millis  results, meaningful while valid is high
//
// Handshake: the client pulses start; busy rises on the next edge.  In the
// last busy cycle valid is high and the result ports hold the final values;
// the client captures them on that same edge, so a conversion with M
// minutes and S seconds spends exactly M+S+1 cycles busy.
module ms_to_mmss
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TIME_W-1:0] value,
  output logic              busy,
  output logic              valid,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [MS_W-1:0]   millis
);

  logic              busy_q, busy_d;
  logic [TIME_W-1:0] work_q, work_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic [SEC_W-1:0]  sec_q,  sec_d;

  always_comb begin
    busy_d = busy_q;
    work_d = work_q;
    min_d  = min_q;
    sec_d  = sec_q;
    valid  = 1'b0;
    if (abort) begin
      busy_d = 1'b0;
      work_d = '0;
      min_d  = '0;
      sec_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      work_d = value;
      min_d  = '0;
      sec_d  = '0;
    end else if (busy_q) begin
      if (work_q >= MS_PER_MIN) begin
        work_d = work_q - MS_PER_MIN;
        min_d  = min_q + MIN_W'(1);
      end else if (work_q >= MS_PER_SEC) begin
        work_d = work_q - MS_PER_SEC;
        sec_d  = sec_q + SEC_W'(1);
      end else begin
        // Remainder is below one second: it is the millis field.
        valid  = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      work_q <= '0;
      min_q  <= '0;
      sec_q  <= '0;
    end else begin
      busy_q <= busy_d;
      work_q <= work_d;
      min_q  <= min_d;
      sec_q  <= sec_d;
    end
  end

  assign busy    = busy_q;
  assign minutes = min_q;
  assign seconds = sec_q;
  // Only meaningful when valid, where work_q < 1000 fits in MS_W bits.
  assign millis  = work_q[MS_W-1:0];

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: millisecond countdown with mm:ss.ms display fields.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   maxtime           programmed duration in ms
//   load/start/stop/clear  one-cycle command pulses, priority
//                     clear > load > stop > start in every state
//   remaining_ms      ms left; minutes/seconds/millis the same value split
//   ready             high in ARMED (start will be accepted)
//   running           high in RUN
//   done              one-cycle pulse on expiry
//   alarm             level, high in DONE
//   dbg_state         current FSM state, for observation
// All outputs are registered.  TICK_DIV clk cycles make one millisecond.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TIME_W-1:0] maxtime,
  input  logic              load,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  output logic [TIME_W-1:0] remaining_ms,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [MS_W-1:0]   millis,
  output logic              ready,
  output logic              running,
  output logic              done,
  output logic              alarm,
  output timer_state_e      dbg_state
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  timer_state_e      state_q, state_d;
  logic [PRE_W-1:0]  pre_q,   pre_d;
  logic [TIME_W-1:0] rem_q,   rem_d;
  logic [MIN_W-1:0]  min_q,   min_d;
  logic [SEC_W-1:0]  sec_q,   sec_d;
  logic [MS_W-1:0]   ms_q,    ms_d;
  logic              ready_q, ready_d;
  logic              run_q,   run_d;
  logic              done_q,  done_d;
  logic              alarm_q, alarm_d;

  logic              tick;
  logic              conv_start, conv_abort;
  logic              conv_busy, conv_valid;
  logic [MIN_W-1:0]  conv_min;
  logic [SEC_W-1:0]  conv_sec;
  logic [MS_W-1:0]   conv_ms;

  // The converter starts on the same edge that moves the FSM into CONVERT,
  // so its step count lines up with the cycles spent in CONVERT.
  assign conv_start = load & ~clear;
  assign conv_abort = clear;

  ms_to_mmss u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (conv_start),
    .abort   (conv_abort),
    .value   (maxtime),
    .busy    (conv_busy),
    .valid   (conv_valid),
    .minutes (conv_min),
    .seconds (conv_sec),
    .millis  (conv_ms)
  );

  assign tick = (state_q == ST_RUN) && (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    min_d   = min_q;
    sec_d   = sec_q;
    ms_d    = ms_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      pre_d   = '0;
      rem_d   = '0;
      min_d   = '0;
      sec_d   = '0;
      ms_d    = '0;
    end else if (load) begin
      state_d = ST_CONVERT;
      pre_d   = '0;
      rem_d   = maxtime;
      min_d   = '0;
      sec_d   = '0;
    end else begin
      case (state_q)
        ST_CONVERT: begin
          if (conv_busy && conv_valid) begin
            min_d   = conv_min;
            sec_d   = conv_sec;
            ms_d    = conv_ms;
            state_d = (rem_q != '0) ? ST_ARMED : ST_IDLE;
          end
        end
        ST_ARMED: begin
          // stop outranks start, so start+stop leaves the timer armed.
          if (start && !stop) state_d = ST_RUN;
        end
        ST_RUN: begin
          // The prescaler counts every RUN cycle, including the one in
          // which stop is sampled; it is held while ARMED so a resume
          // keeps the partial millisecond.
          if (tick) begin
            pre_d = '0;
            if (rem_q != '0) begin
              rem_d = rem_q - TIME_W'(1);
              if (ms_q == '0) begin
                ms_d = MS_W'(999);
                if (sec_q == '0) begin
                  sec_d = SEC_W'(59);
                  min_d = min_q - MIN_W'(1);
                end else begin
                  sec_d = sec_q - SEC_W'(1);
                end
              end else begin
                ms_d = ms_q - MS_W'(1);
              end
              if (rem_q == TIME_W'(1)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
          if (stop && state_d == ST_RUN) state_d = ST_ARMED;
        end
        default: ;
      endcase
    end
    ready_d = (state_d == ST_ARMED);
    run_d   = (state_d == ST_RUN);
    alarm_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      rem_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      ms_q    <= '0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ms_q    <= ms_d;
      ready_q <= ready_d;
      run_q   <= run_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
    end
  end

  assign remaining_ms = rem_q;
  assign minutes      = min_q;
  assign seconds      = sec_q;
  assign millis       = ms_q;
  assign ready        = ready_q;
  assign running      = run_q;
  assign done         = done_q;
  assign alarm        = alarm_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with TICK_DIV=4.
module tb_countdown_timer;
  import timer_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int EXP_W    = 45; // {remaining(22), min(7), sec(6), ms(10)}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [TIME_W-1:0] maxtime = '0;
  logic load = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [TIME_W-1:0] remaining_ms;
  logic [MIN_W-1:0]  minutes;
  logic [SEC_W-1:0]  seconds;
  logic [MS_W-1:0]   millis;
  logic ready, running, done, alarm;
  timer_state_e dbg_state;

  countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .maxtime      (maxtime),
    .load         (load),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .remaining_ms (remaining_ms),
    .minutes      (minutes),
    .seconds      (seconds),
    .millis       (millis),
    .ready        (ready),
    .running      (running),
    .done         (done),
    .alarm        (alarm),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference split of a millisecond count by division.
  function automatic logic [EXP_W-1:0] model(input int unsigned t);
    return {22'(t), 7'(t / 60000), 6'((t % 60000) / 1000), 10'(t % 1000)};
  endfunction

  function automatic logic [EXP_W-1:0] observed();
    return {remaining_ms, minutes, seconds, millis};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int unsigned v);
    maxtime = 22'(v);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget) begin
      step();
      n++;
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    checks++;
    if ({observed(), ready, running, done, alarm} !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset: outputs=%h state=%0d, required all zero / IDLE",
               {observed(), ready, running, done, alarm}, dbg_state);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_convert(input int unsigned t);
    int n;
    bit ok;
    logic [EXP_W-1:0] exp;
    int exp_n;
    exp_q.push_back(model(t));
    do_load(t);
    wait_ready(200, n, ok);
    exp = exp_q.pop_front();
    exp_n = int'(exp[22:16]) + int'(exp[15:10]) + 1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL convert_timeout t=%0d: ready never rose within 200 cycles", t);
    end else begin
      checks++;
      if (n !== exp_n) begin
        errors++;
        $display("FAIL convert_cycles t=%0d: got %0d cycles, required %0d", t, n, exp_n);
      end
      checks++;
      if (observed() !== exp || running !== 1'b0) begin
        errors++;
        $display("FAIL convert_fields t=%0d: got %h run=%b, required %h run=0",
                 t, observed(), running, exp);
      end
    end
  endtask

  task automatic test_convert_zero();
    do_load(0);
    step();
    checks++;
    if (dbg_state !== ST_IDLE || ready !== 1'b0 || remaining_ms !== '0) begin
      errors++;
      $display("FAIL convert_zero: state=%0d ready=%b rem=%0d, required IDLE/0/0",
               dbg_state, ready, remaining_ms);
    end
    do_start();
    step();
    checks++;
    if (dbg_state !== ST_IDLE || running !== 1'b0) begin
      errors++;
      $display("FAIL start_in_idle: state=%0d running=%b, required IDLE/0", dbg_state, running);
    end
  endtask

  // Runs ticks countdown steps and compares each new value with the model.
  task automatic test_countdown(input int unsigned t, input int ticks);
    int n;
    bit ok;
    int gap;
    logic [TIME_W-1:0] prev;
    logic [EXP_W-1:0] exp;
    test_convert(t);
    for (int k = 1; k <= ticks; k++) exp_q.push_back(model(t - k));
    do_start();
    checks++;
    if (running !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL start_run t=%0d: running=%b ready=%b, required 1/0", t, running, ready);
    end
    for (int k = 0; k < ticks; k++) begin
      prev = remaining_ms;
      gap = 0;
      ok = 1'b0;
      while (gap < 4 * TICK_DIV) begin
        step();
        gap++;
        if (remaining_ms !== prev) begin
          ok = 1'b1;
          break;
        end
      end
      exp = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL tick_timeout t=%0d tick=%0d: no decrement in %0d cycles", t, k, gap);
      end else begin
        checks++;
        if (gap !== TICK_DIV) begin
          errors++;
          $display("FAIL tick_gap t=%0d tick=%0d: got %0d cycles, required %0d", t, k, gap, TICK_DIV);
        end
        checks++;
        if (observed() !== exp) begin
          errors++;
          $display("FAIL tick_value t=%0d tick=%0d: got %h, required %h", t, k, observed(), exp);
        end
      end
    end
    n = 0;
    do_clear();
  endtask

  task automatic test_done();
    int n;
    bit ok;
    logic [TIME_W-1:0] exp_rem;
    test_convert(2);
    do_start();
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_rem = (k < 4) ? 22'd2 : (k < 8) ? 22'd1 : 22'd0;
      checks++;
      if (remaining_ms !== exp_rem || done !== (k == 8) || alarm !== (k >= 8)) begin
        errors++;
        $display("FAIL done_seq k=%0d: rem=%0d done=%b alarm=%b, required %0d/%b/%b",
                 k, remaining_ms, done, alarm, exp_rem, (k == 8), (k >= 8));
      end
    end
    do_start();
    do_stop();
    repeat (6) step();
    checks++;
    if (alarm !== 1'b1 || remaining_ms !== '0 || running !== 1'b0 || dbg_state !== ST_DONE) begin
      errors++;
      $display("FAIL done_hold: alarm=%b rem=%0d running=%b state=%0d, required 1/0/0/DONE",
               alarm, remaining_ms, running, dbg_state);
    end
    do_clear();
    checks++;
    if (alarm !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL done_clear: alarm=%b state=%0d, required 0/IDLE", alarm, dbg_state);
    end
    n = 0;
    ok = 1'b0;
  endtask

  task automatic test_stop_resume();
    int gap;
    test_convert(5000);
    do_start();
    gap = 0;
    while (gap < 4 * TICK_DIV && remaining_ms == 22'd5000) begin
      step();
      gap++;
    end
    checks++;
    if (remaining_ms !== 22'd4999) begin
      errors++;
      $display("FAIL first_tick: rem=%0d, required 4999", remaining_ms);
    end
    // Stop sampled two edges after the tick edge.
    step();
    do_stop();
    checks++;
    if (ready !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL stop: ready=%b running=%b, required 1/0", ready, running);
    end
    repeat (10) step();
    checks++;
    if (observed() !== model(4999)) begin
      errors++;
      $display("FAIL armed_hold: got %h, required %h", observed(), model(4999));
    end
    do_start();
    step();
    checks++;
    if (remaining_ms !== 22'd4999) begin
      errors++;
      $display("FAIL resume_early: rem=%0d one cycle after resume, required 4999", remaining_ms);
    end
    step();
    checks++;
    if (observed() !== model(4998)) begin
      errors++;
      $display("FAIL resume_tick: got %h two cycles after resume, required %h",
               observed(), model(4998));
    end
    start = 1'b1;
    stop = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_run: ready=%b running=%b, required 1/0", ready, running);
    end
    step();
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (ready !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_armed: ready=%b running=%b, required 1/0", ready, running);
    end
    do_clear();
  endtask

  task automatic test_reset_mid();
    test_convert(3000);
    do_start();
    repeat (3) step();
    rst_n = 1'b0;
    start = 1'b1;
    step();
    checks++;
    if ({observed(), ready, running, done, alarm} !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid_run: outputs=%h state=%0d, required zero/IDLE",
               {observed(), ready, running, done, alarm}, dbg_state);
    end
    rst_n = 1'b1;
    start = 1'b0;
    do_load(4194303);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (130) step();
    checks++;
    if ({observed(), ready, running, done, alarm} !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid_convert: outputs=%h state=%0d, required zero/IDLE",
               {observed(), ready, running, done, alarm}, dbg_state);
    end
  endtask

  task automatic test_clear_load();
    test_convert(3000);
    do_start();
    repeat (6) step();
    maxtime = 22'd5000;
    clear = 1'b1;
    load = 1'b1;
    step();
    clear = 1'b0;
    load = 1'b0;
    checks++;
    if ({observed(), ready, running, done, alarm} !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL clear_load: outputs=%h state=%0d, required zero/IDLE",
               {observed(), ready, running, done, alarm}, dbg_state);
    end
    repeat (10) step();
    checks++;
    if (ready !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL clear_load_settle: ready=%b state=%0d, required 0/IDLE", ready, dbg_state);
    end
  endtask

  task automatic test_reload_in_convert();
    do_load(4194303);
    repeat (10) step();
    test_convert(61500);
    do_clear();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    test_reset();
    test_convert(61500);
    do_clear();
    test_convert(4194303);
    do_clear();
    test_convert($urandom_range(1, 4194303));
    do_clear();
    test_convert_zero();
    test_done();
    test_countdown(1000, 2);
    test_countdown(60000, 1);
    test_countdown($urandom_range(1001, 200000), 3);
    test_stop_resume();
    test_reload_in_convert();
    test_clear_load();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
